// File: rtl/madam_matrix_engine.sv
// MADAM matrix engine: sequential single-MAC 16.16 matrix x vector unit.
// Optional perspective divide for cmd 3 is built when MATRIX_DIVIDE_EN is defined.
module madam_matrix_engine #(
   parameter int MAX_DIM   = 4,
   parameter int FRAC_BITS = 16,
   parameter int DIV_STEPS = 64
) (
   input  logic        clk_25m,
   input  logic        reset,
   input  logic [10:0] cpu_addr,
   input  logic [31:0] cpu_din,
   input  logic        cpu_wen,
   output logic [31:0] cpu_dout,
   output logic        busy,
   output logic        done
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_MAC  = 3'd1;
   localparam logic [2:0] S_WB   = 3'd2;
`ifdef MATRIX_DIVIDE_EN
   localparam logic [2:0] S_DIV     = 3'd3;
   localparam logic [2:0] S_SCALE_X = 3'd4;
   localparam logic [2:0] S_SCALE_Y = 3'd5;
   localparam int DCW = $clog2(DIV_STEPS + 1);
`endif

   localparam logic signed [63:0] RND =
      (64'sd1 <<< FRAC_BITS) - 64'sd1;

   logic [31:0] m [4][4];
   logic [31:0] v [4];
   logic [31:0] rez [4];
   logic [31:0] rezt [4];
   logic [63:0] nfrac;

   logic [2:0]  state;
   logic [1:0]  col;
   logic [1:0]  rstep;
   logic [1:0]  last;
   logic [1:0]  row;
   logic        is_div;
   logic signed [63:0] acc;

   logic        in_win;
   logic [6:0]  ofs;
   logic        wr_ok;
   logic        cmd_wr;
   logic        start_4;
   logic        start_3;
   logic        start_d;
   logic [31:0] rdata;

   logic signed [63:0] mac_prod;
   logic signed [63:0] acc_adj;
   logic [31:0] wb_val;

   assign in_win = (cpu_addr[10:9] == 2'b11);
   assign ofs    = cpu_addr[8:2];
   assign wr_ok  = cpu_wen && !busy && in_win;
   assign cmd_wr = wr_ok && (ofs == 7'h7F);

   assign start_4 = cmd_wr && (cpu_din == 32'd1) && (MAX_DIM == 4);
   assign start_3 = cmd_wr && (cpu_din == 32'd2);
`ifdef MATRIX_DIVIDE_EN
   assign start_d = cmd_wr && (cpu_din == 32'd3);
`else
   assign start_d = 1'b0;
`endif

   assign busy = (state != S_IDLE);
`ifdef MATRIX_DIVIDE_EN
   assign done = (state == S_WB && rstep == last && !is_div)
              || (state == S_SCALE_Y);
`else
   assign done = (state == S_WB && rstep == last && !is_div);
`endif

   // Row visit order: cmd 3 computes z first so the divide can start early
   always_comb begin
      row = rstep;
      if (is_div) begin
         case (rstep)
            2'd0:    row = 2'd2;
            2'd1:    row = 2'd0;
            default: row = 2'd1;
         endcase
      end
   end

   assign mac_prod = $signed({{32{m[row][col][31]}}, m[row][col]})
                   * $signed({{32{v[col][31]}}, v[col]});
   assign acc_adj  = acc + (acc[63] ? RND : 64'sd0);
   assign wb_val   = 32'(acc_adj >>> FRAC_BITS);

`ifdef MATRIX_DIVIDE_EN
   logic [63:0] quo;
   logic [63:0] rem;
   logic [63:0] den;
   logic        neg;
   logic        zflag;
   logic [DCW-1:0] dcnt;
   logic [64:0] sh;
   logic [64:0] diff;
   logic [63:0] mq;
   logic [31:0] sc_in;
   logic signed [95:0] sc_prod;
   logic signed [95:0] sc_adj;
   logic [31:0] sc_val;

   assign sh   = {rem, quo[63]};
   assign diff = sh - {1'b0, den};
   assign mq   = zflag ? nfrac : (neg ? -quo : quo);

   assign sc_in   = (state == S_SCALE_X) ? rezt[0] : rezt[1];
   assign sc_prod = $signed({{64{sc_in[31]}}, sc_in})
                  * $signed({{32{mq[63]}}, mq});
   assign sc_adj  = sc_prod
                  + (sc_prod[95] ? 96'sh0_FFFF_FFFF : 96'sd0);
   assign sc_val  = 32'(sc_adj >>> 32);

   // Restoring divider: |NFRAC| / |z|, one quotient bit per cycle
   always_ff @(posedge clk_25m) begin
      if (reset) begin
         quo   <= '0;
         rem   <= '0;
         den   <= '0;
         neg   <= 1'b0;
         zflag <= 1'b0;
         dcnt  <= '0;
      end else if (state == S_WB && rstep == last && is_div) begin
         quo   <= nfrac[63] ? -nfrac : nfrac;
         rem   <= '0;
         den   <= {32'd0, rezt[2][31] ? -rezt[2] : rezt[2]};
         neg   <= nfrac[63] ^ rezt[2][31];
         zflag <= (rezt[2] == 32'd0);
         dcnt  <= '0;
      end else if (state == S_DIV) begin
         dcnt <= dcnt + 1'b1;
         if (!zflag) begin
            if (!diff[64]) begin
               rem <= 64'(diff);
               quo <= {quo[62:0], 1'b1};
            end else begin
               rem <= 64'(sh);
               quo <= {quo[62:0], 1'b0};
            end
         end
      end
   end
`endif

   // CPU-visible register file; all writes blocked while a command runs
   always_ff @(posedge clk_25m) begin
      if (reset) begin
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) m[r][c] <= '0;
            v[r]   <= '0;
            rez[r] <= '0;
         end
         nfrac <= '0;
      end else if (wr_ok) begin
         unique case (1'b1)
            (ofs[6:4] == 3'b000):
               m[ofs[3:2]][ofs[1:0]] <= cpu_din;
            (ofs[6:2] == 5'b00100):
               v[ofs[1:0]] <= cpu_din;
            (ofs == 7'd32):
               nfrac[63:32] <= cpu_din;
            (ofs == 7'd33):
               nfrac[31:0] <= cpu_din;
            (ofs == 7'h7F):
               for (int r = 0; r < 4; r++) rez[r] <= rezt[r];
            default: ;
         endcase
      end
   end

   // Read mux; unmapped offsets read as zero
   always_comb begin
      rdata = '0;
      if (in_win) begin
         unique case (1'b1)
            (ofs[6:4] == 3'b000):  rdata = m[ofs[3:2]][ofs[1:0]];
            (ofs[6:2] == 5'b00100): rdata = v[ofs[1:0]];
            (ofs[6:2] == 5'b00110): rdata = rez[ofs[1:0]];
            (ofs == 7'd32):        rdata = nfrac[63:32];
            (ofs == 7'd33):        rdata = nfrac[31:0];
            (ofs == 7'h7F):        rdata = {31'd0, busy};
            default:               rdata = '0;
         endcase
      end
   end

   // Registered read port
   always_ff @(posedge clk_25m) begin
      if (reset) cpu_dout <= '0;
      else       cpu_dout <= rdata;
   end

   // Command sequencer: MAC/WB per row, then optional divide and scale
   always_ff @(posedge clk_25m) begin
      if (reset) begin
         state  <= S_IDLE;
         col    <= '0;
         rstep  <= '0;
         last   <= '0;
         is_div <= 1'b0;
         acc    <= '0;
         for (int r = 0; r < 4; r++) rezt[r] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_4 || start_3 || start_d) begin
                  state  <= S_MAC;
                  col    <= '0;
                  rstep  <= '0;
                  acc    <= '0;
                  last   <= start_4 ? 2'd3 : 2'd2;
                  is_div <= start_d;
               end
            end
            S_MAC: begin
               acc <= acc + mac_prod;
               if (col == last) state <= S_WB;
               else             col   <= col + 1'b1;
            end
            S_WB: begin
               rezt[row] <= wb_val;
               acc       <= '0;
               col       <= '0;
               if (rstep == last) begin
`ifdef MATRIX_DIVIDE_EN
                  state <= is_div ? S_DIV : S_IDLE;
`else
                  state <= S_IDLE;
`endif
               end else begin
                  rstep <= rstep + 1'b1;
                  state <= S_MAC;
               end
            end
`ifdef MATRIX_DIVIDE_EN
            S_DIV: begin
               if (dcnt == DCW'(DIV_STEPS - 1)) state <= S_SCALE_X;
            end
            S_SCALE_X: begin
               rezt[0] <= sc_val;
               state   <= S_SCALE_Y;
            end
            S_SCALE_Y: begin
               rezt[1] <= sc_val;
               state   <= S_IDLE;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_madam_matrix_engine.sv
// Directed self-checking bench for madam_matrix_engine.
// Divide scenarios are exercised when MATRIX_DIVIDE_EN is defined.
module tb_madam_matrix_engine;

   localparam logic [10:0] A_M   = 11'h600;
   localparam logic [10:0] A_V   = 11'h640;
   localparam logic [10:0] A_REZ = 11'h660;
   localparam logic [10:0] A_NHI = 11'h680;
   localparam logic [10:0] A_NLO = 11'h684;
   localparam logic [10:0] A_CMD = 11'h7FC;

   logic        clk_25m = 1'b0;
   logic        reset = 1'b1;
   logic [10:0] cpu_addr = '0;
   logic [31:0] cpu_din = '0;
   logic        cpu_wen = 1'b0;
   logic [31:0] cpu_dout;
   logic        busy;
   logic        done;

   int asserts = 0;
   int fails = 0;

   madam_matrix_engine dut (
      .clk_25m  (clk_25m),
      .reset    (reset),
      .cpu_addr (cpu_addr),
      .cpu_din  (cpu_din),
      .cpu_wen  (cpu_wen),
      .cpu_dout (cpu_dout),
      .busy     (busy),
      .done     (done)
   );

   always #20 clk_25m = ~clk_25m;

   // All bus tasks start and end at a falling edge and use one cycle
   task automatic wr(input logic [10:0] a, input logic [31:0] d);
      cpu_addr = a;
      cpu_din  = d;
      cpu_wen  = 1'b1;
      @(negedge clk_25m);
      cpu_wen  = 1'b0;
   endtask

   task automatic rd(input logic [10:0] a, output logic [31:0] d);
      cpu_addr = a;
      @(posedge clk_25m);
      #1 d = cpu_dout;
      @(negedge clk_25m);
   endtask

   task automatic wait_idle(input int start, output int cnt,
                            output int dones, output int done_at);
      cnt = start;
      dones = 0;
      done_at = -1;
      while (busy && cnt < 200) begin
         if (done) begin
            dones++;
            done_at = cnt;
         end
         cnt++;
         @(negedge clk_25m);
      end
   endtask

   task automatic load_identity();
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            wr(A_M + 11'(16 * r + 4 * c), (r == c) ? 32'h10000 : 32'h0);
      for (int i = 0; i < 4; i++)
         wr(A_V + 11'(4 * i), 32'h10000 * 32'(i + 1));
   endtask

   task automatic test_reset();
      logic [31:0] d;
      reset = 1'b1;
      repeat (3) @(negedge clk_25m);
      asserts++;
      if (busy !== 1'b0 || done !== 1'b0 || cpu_dout !== 32'd0) begin
         fails++;
         $display("FAIL reset_outputs busy=%b done=%b dout=%h want 0 0 0",
                  busy, done, cpu_dout);
      end
      reset = 1'b0;
      rd(A_M, d);
      asserts++;
      if (d !== 32'd0) begin
         fails++;
         $display("FAIL reset_m00 got %h want 0", d);
      end
      wr(11'h6F0, 32'hDEADBEEF);
      rd(11'h6F0, d);
      asserts++;
      if (d !== 32'd0) begin
         fails++;
         $display("FAIL unmapped_read got %h want 0", d);
      end
   endtask

   task automatic test_mat4();
      logic [31:0] d;
      int cnt, dones, done_at;
      load_identity();
      wr(A_CMD, 32'd1);
      wait_idle(0, cnt, dones, done_at);
      asserts++;
      if (cnt !== 20 || dones !== 1 || done_at !== 19) begin
         fails++;
         $display("FAIL cmd1_timing cycles=%0d dones=%0d at=%0d want 20 1 19",
                  cnt, dones, done_at);
      end
      rd(A_REZ, d);
      asserts++;
      if (d !== 32'd0) begin
         fails++;
         $display("FAIL cmd1_rez_unpublished got %h want 0", d);
      end
      wr(A_CMD, 32'd0);
      for (int i = 0; i < 4; i++) begin
         rd(A_REZ + 11'(4 * i), d);
         asserts++;
         if (d !== 32'h10000 * 32'(i + 1)) begin
            fails++;
            $display("FAIL cmd1_rez%0d got %h want %h",
                     i, d, 32'h10000 * 32'(i + 1));
         end
      end
   endtask

   task automatic test_toward_zero();
      logic [31:0] d;
      int cnt, dones, done_at;
      wr(A_M, 32'hFFFFFFFF);
      wr(A_M + 11'h14, 32'h0);
      wr(A_M + 11'h28, 32'h0);
      wr(A_M + 11'h3C, 32'h0);
      wr(A_V, 32'd1);
      for (int i = 1; i < 4; i++) wr(A_V + 11'(4 * i), 32'h0);
      wr(A_CMD, 32'd2);
      wait_idle(0, cnt, dones, done_at);
      asserts++;
      if (cnt !== 12 || dones !== 1 || done_at !== 11) begin
         fails++;
         $display("FAIL cmd2_timing cycles=%0d dones=%0d at=%0d want 12 1 11",
                  cnt, dones, done_at);
      end
      wr(A_CMD, 32'd0);
      rd(A_REZ, d);
      asserts++;
      if (d !== 32'd0) begin
         fails++;
         $display("FAIL cmd2_rez0_trunc got %h want 0", d);
      end
      rd(A_REZ + 11'hC, d);
      asserts++;
      if (d !== 32'h40000) begin
         fails++;
         $display("FAIL cmd2_rez3_kept got %h want 00040000", d);
      end
   endtask

`ifdef MATRIX_DIVIDE_EN
   task automatic test_divide();
      logic [31:0] d;
      int cnt, dones, done_at;
      logic [31:0] exp_a [3];
      logic [31:0] exp_b [3];
      exp_a[0] = 32'h20000; exp_a[1] = 32'h10000; exp_a[2] = 32'h20000;
      exp_b[0] = 32'h0;     exp_b[1] = 32'h0;     exp_b[2] = 32'h0;
      wr(A_M, 32'h10000);
      wr(A_M + 11'h14, 32'h10000);
      wr(A_M + 11'h28, 32'h10000);
      wr(A_V, 32'h40000);
      wr(A_V + 11'h4, 32'h20000);
      wr(A_V + 11'h8, 32'h20000);
      wr(A_NHI, 32'h00010000);
      wr(A_NLO, 32'h0);
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 1) wr(A_V + 11'h8, 32'h0);
         wr(A_CMD, 32'd3);
         wait_idle(0, cnt, dones, done_at);
         asserts++;
         if (cnt !== 78 || dones !== 1 || done_at !== 77) begin
            fails++;
            $display("FAIL cmd3_timing p%0d cycles=%0d dones=%0d at=%0d want 78 1 77",
                     pass, cnt, dones, done_at);
         end
         wr(A_CMD, 32'd0);
         for (int i = 0; i < 3; i++) begin
            rd(A_REZ + 11'(4 * i), d);
            asserts++;
            if (d !== (pass == 0 ? exp_a[i] : exp_b[i])) begin
               fails++;
               $display("FAIL cmd3_rez%0d p%0d got %h want %h", i, pass, d,
                        pass == 0 ? exp_a[i] : exp_b[i]);
            end
         end
      end
   endtask
`else
   task automatic test_no_divide();
      int seen;
      seen = 0;
      wr(A_CMD, 32'd3);
      for (int i = 0; i < 8; i++) begin
         if (busy || done) seen++;
         @(negedge clk_25m);
      end
      asserts++;
      if (seen !== 0) begin
         fails++;
         $display("FAIL cmd3_unknown busy/done cycles=%0d want 0", seen);
      end
   endtask
`endif

   task automatic test_back_to_back();
      logic [31:0] d;
      logic [31:0] st;
      int cnt, dones, done_at;
      load_identity();
      wr(A_CMD, 32'd1);
      wr(A_V, 32'h99);
      wr(A_CMD, 32'd2);
      rd(A_CMD, st);
      asserts++;
      if (st !== 32'd1) begin
         fails++;
         $display("FAIL busy_status got %h want 1", st);
      end
      wait_idle(3, cnt, dones, done_at);
      asserts++;
      if (cnt !== 20 || dones !== 1) begin
         fails++;
         $display("FAIL blocked_cmd_timing cycles=%0d dones=%0d want 20 1",
                  cnt, dones);
      end
      rd(A_V, d);
      asserts++;
      if (d !== 32'h10000) begin
         fails++;
         $display("FAIL blocked_v0 got %h want 00010000", d);
      end
      wr(A_CMD, 32'd0);
      for (int i = 0; i < 4; i++) begin
         rd(A_REZ + 11'(4 * i), d);
         asserts++;
         if (d !== 32'h10000 * 32'(i + 1)) begin
            fails++;
            $display("FAIL blocked_rez%0d got %h want %h",
                     i, d, 32'h10000 * 32'(i + 1));
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] d;
      int dones;
      dones = 0;
      wr(A_CMD, 32'd1);
      for (int i = 0; i < 4; i++) begin
         if (done) dones++;
         @(negedge clk_25m);
      end
      reset = 1'b1;
      if (done) dones++;
      @(negedge clk_25m);
      reset = 1'b0;
      asserts++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL abort_busy got %b want 0", busy);
      end
      for (int i = 0; i < 25; i++) begin
         if (done) dones++;
         @(negedge clk_25m);
      end
      asserts++;
      if (dones !== 0) begin
         fails++;
         $display("FAIL abort_done pulses=%0d want 0", dones);
      end
      for (int i = 0; i < 4; i++) begin
         rd(A_REZ + 11'(4 * i), d);
         asserts++;
         if (d !== 32'd0) begin
            fails++;
            $display("FAIL abort_rez%0d got %h want 0", i, d);
         end
      end
      rd(A_M, d);
      asserts++;
      if (d !== 32'd0) begin
         fails++;
         $display("FAIL abort_m00 got %h want 0", d);
      end
      rd(A_V, d);
      asserts++;
      if (d !== 32'd0) begin
         fails++;
         $display("FAIL abort_v0 got %h want 0", d);
      end
   endtask

   initial begin
      @(negedge clk_25m);
      test_reset();
      test_mat4();
      test_toward_zero();
`ifdef MATRIX_DIVIDE_EN
      test_divide();
`else
      test_no_divide();
`endif
      test_back_to_back();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures",
               asserts, fails);
      $finish;
   end

endmodule
